// File: rtl/ifu_prefetch_if.sv
// Fetch-stage bus: redirect/stall control, IF/ID presentation and the imem request/response channel.
// The fetch_err status bit exists only when IFU_ALIGN_CHECK_EN is defined.
interface ifu_prefetch_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_ir;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
`ifdef IFU_ALIGN_CHECK_EN
  logic        fetch_err;
`endif

  modport master (
    input  redirect, redirect_pc, stall, imem_gnt, imem_rvalid, imem_rdata,
    output out_valid, out_pc, out_ir, imem_req, imem_addr
`ifdef IFU_ALIGN_CHECK_EN
    , output fetch_err
`endif
  );

  modport slave (
    output redirect, redirect_pc, stall, imem_gnt, imem_rvalid, imem_rdata,
    input  out_valid, out_pc, out_ir, imem_req, imem_addr
`ifdef IFU_ALIGN_CHECK_EN
    , input fetch_err
`endif
  );
endinterface

// File: rtl/ifu_prefetch.sv
// Instruction fetch stage with an in-order prefetch queue and redirect flush of stale responses.
// Optional IFU_ALIGN_CHECK_EN: misaligned redirect sets sticky fetch_err and delivers a nop first.
module ifu_prefetch #(
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  ifu_prefetch_if.master  bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int DW = $clog2(MAX_OUT) + 1;
  localparam int QW = $clog2(DEPTH);
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  logic [31:0]   r_q_pc [DEPTH];
  logic [31:0]   r_q_ir [DEPTH];
  logic [QW-1:0] r_head;
  logic [QW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [DW-1:0] r_discard;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_tag [MAX_OUT];
  logic [PW-1:0] r_tag_wr;
  logic [PW-1:0] r_tag_rd;

  logic          w_req;
  logic          w_gnt;
  logic          w_push;
  logic          w_pop;
  logic          w_out_valid;
  logic [CW:0]   w_credit;
  logic [31:0]   w_redirect_pc;
  logic [31:0]   w_push_ir;
  logic [CW-1:0] w_count_nxt;
  logic [CW-1:0] w_outstanding_nxt;
  logic [DW-1:0] w_discard_nxt;

  function automatic logic [PW-1:0] tag_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
  endfunction

  // Queue occupancy plus in-flight fetches never exceeds DEPTH, so a push always has room.
  assign w_credit      = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_req         = !reset && !bus.redirect
                         && (r_outstanding < CW'(MAX_OUT))
                         && (w_credit < (CW+1)'(DEPTH));
  assign w_gnt         = w_req && bus.imem_gnt;
  assign w_out_valid   = (r_count != '0);
  assign w_push        = bus.imem_rvalid && (r_discard == '0) && !bus.redirect;
  assign w_pop         = w_out_valid && !bus.stall && !bus.redirect;
  assign w_redirect_pc = bus.redirect_pc & ~32'h3;

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = r_fetch_pc;
  assign bus.out_valid = w_out_valid;
  assign bus.out_pc    = w_out_valid ? r_q_pc[r_head] : '0;
  assign bus.out_ir    = w_out_valid ? r_q_ir[r_head] : '0;

`ifdef IFU_ALIGN_CHECK_EN
  logic r_fetch_err;
  logic r_nop_pending;
  logic w_misaligned;

  assign w_misaligned  = (bus.redirect_pc[1:0] != 2'b00);
  assign w_push_ir     = r_nop_pending ? 32'h0 : bus.imem_rdata;
  assign bus.fetch_err = r_fetch_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_err   <= 1'b0;
      r_nop_pending <= 1'b0;
    end else if (bus.redirect) begin
      r_fetch_err   <= r_fetch_err | w_misaligned;
      r_nop_pending <= w_misaligned;
    end else if (w_push) begin
      r_nop_pending <= 1'b0;
    end
  end
`else
  assign w_push_ir = bus.imem_rdata;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_count_nxt       = r_count;
    w_outstanding_nxt = r_outstanding + CW'(w_gnt) - CW'(bus.imem_rvalid);
    w_discard_nxt     = r_discard;
    if (bus.redirect) begin
      w_count_nxt   = '0;
      // Everything still in flight after this cycle's accounting belongs to the old stream.
      w_discard_nxt = DW'(w_outstanding_nxt);
    end else begin
      w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
      if (bus.imem_rvalid && (r_discard != '0))
        w_discard_nxt = r_discard - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_fetch_pc    <= RESET_PC;
      r_tag_wr      <= '0;
      r_tag_rd      <= '0;
    end else begin
      r_count       <= w_count_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_discard     <= w_discard_nxt;
      if (w_gnt)            r_tag_wr <= tag_inc(r_tag_wr);
      if (bus.imem_rvalid)  r_tag_rd <= tag_inc(r_tag_rd);
      if (bus.redirect) begin
        r_head     <= '0;
        r_tail     <= '0;
        r_fetch_pc <= w_redirect_pc;
      end else begin
        if (w_push) r_tail <= r_tail + 1'b1;
        if (w_pop)  r_head <= r_head + 1'b1;
        if (w_gnt)  r_fetch_pc <= r_fetch_pc + 32'd4;
      end
    end
  end

  // NOTE: storage arrays are not reset; pointers and count decide what is valid and outputs are gated by out_valid.
  always_ff @(posedge clk) begin
    if (w_gnt)
      r_tag[r_tag_wr] <= r_fetch_pc;
    if (w_push) begin
      r_q_pc[r_tail] <= r_tag[r_tag_rd];
      r_q_ir[r_tail] <= w_push_ir;
    end
  end

endmodule
